// File: rtl/multdiv_ctrl_pkg.sv
// multdiv_ctrl_pkg: shared state, op encoding and exception record codes for multdiv_ctrl
package multdiv_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int RSTATUS_REG = 30;
  localparam int EXC_MULT = 4;
  localparam int EXC_DIV = 5;
  localparam int EXC_TIMEOUT = 6;
endpackage

// File: rtl/md_watchdog.sv
// md_watchdog: counts enabled cycles and flags the one that reaches LIMIT
module md_watchdog #(
  parameter int LIMIT = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = enable && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div op through the multdiv unit to writeback.
// Define MULTDIV_TIMEOUT_EN to add a BUSY watchdog that ends the op with an EXC_TIMEOUT record.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [REG_W-1:0]  req_rd,
  input  logic              flush,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_rdy,
  input  logic              wb_ready,
  output logic              req_ready,
  output logic              stall,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exc
);
  state_t state, state_nxt;
  logic op_q;
  logic [REG_W-1:0] rd_q;
  logic accept, capture, expired, exc;
`ifdef MULTDIV_TIMEOUT_EN
  md_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clock),
    .rst(reset),
    .clear(state != BUSY),
    .enable(state == BUSY && !md_rdy),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
  assign accept = req_valid && req_ready;
  assign capture = state == BUSY && !flush && (md_rdy || expired);
  // a capture without md_rdy can only be a watchdog expiry
  assign exc = !md_rdy || md_exception;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (accept ? START : IDLE) :
                flush         ? IDLE :
                state == START ? BUSY :
                state == BUSY  ? (capture ? DONE : BUSY) :
                wb_ready       ? IDLE : DONE;
  always_comb begin
    req_ready = state == IDLE && !flush;
    stall = state != IDLE || req_valid;
    md_ctrl_mult = state == START && op_q == OP_MULT;
    md_ctrl_div = state == START && op_q == OP_DIV;
    wb_valid = state == DONE && !flush;
  end
  always_ff @(posedge clock)
    if (reset) begin
      op_q <= OP_MULT;
      rd_q <= '0;
      md_operandA <= '0;
      md_operandB <= '0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_exc <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        rd_q <= req_rd;
        md_operandA <= req_a;
        md_operandB <= req_b;
      end
      if (capture) begin
        wb_exc <= exc;
        wb_rd <= exc ? REG_W'(RSTATUS_REG) : rd_q;
        wb_data <= !md_rdy ? DATA_W'(EXC_TIMEOUT) :
                   md_exception ? DATA_W'(op_q == OP_DIV ? EXC_DIV : EXC_MULT) : md_result;
      end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed vectors plus flush/reset/backpressure sequences; the bench plays the multdiv unit
module tb_multdiv_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_op = 1'b0, flush = 1'b0;
  logic md_exception = 1'b0, md_rdy = 1'b0, wb_ready = 1'b0;
  logic [31:0] req_a = '0, req_b = '0, md_result = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, stall, md_ctrl_mult, md_ctrl_div, wb_valid, wb_exc;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0] wb_rd;
  int n_cmp = 0;
  int n_err = 0;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .md_result(md_result), .md_exception(md_exception), .md_rdy(md_rdy),
    .wb_ready(wb_ready), .req_ready(req_ready), .stall(stall),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic op;
    logic [31:0] a, b;
    logic [4:0] rd;
    int dly;
    logic [31:0] res;
    logic exc;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    logic e_exc;
  } vec_t;

  vec_t vecs[6];

  // accept a request in IDLE, then check the START-cycle pulse and operands
  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    #1 chk("accept_ready", req_ready, 1);
    chk("accept_stall", stall, 1);
    @(negedge clock);
    req_valid = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'hFFFF_FFFF;
    #1 chk("start_pulse", {md_ctrl_div, md_ctrl_mult}, op ? 32'd2 : 32'd1);
    chk("start_opA", md_operandA, a);
    chk("start_opB", md_operandB, b);
  endtask

  task automatic run_vec(input vec_t v);
    wb_ready = 1'b1;
    start_op(v.op, v.a, v.b, v.rd);
    for (int i = 0; i <= v.dly; i++) begin
      @(negedge clock);
      md_rdy = i == v.dly;
      md_result = md_rdy ? v.res : 32'hBAD0_BAD0;
      md_exception = md_rdy && v.exc;
      #1 chk("busy_no_pulse", {md_ctrl_div, md_ctrl_mult}, 0);
      chk("busy_no_wb", wb_valid, 0);
      chk("busy_stall", stall, 1);
      chk("busy_opA", md_operandA, v.a);
    end
    @(negedge clock);
    md_rdy = 1'b0; md_exception = 1'b0; md_result = '0;
    #1 chk("done_valid", wb_valid, 1);
    chk("done_rd", wb_rd, v.e_rd);
    chk("done_data", wb_data, v.e_data);
    chk("done_exc", wb_exc, v.e_exc);
    chk("done_opB", md_operandB, v.b);
    chk("done_stall", stall, 1);
    @(negedge clock);
    #1 chk("idle_no_wb", wb_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_stall", stall, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'd7, 32'd6, 5'd3, 3, 32'd42, 1'b0, 5'd3, 32'd42, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C, 32'd7, 5'd9, 6, 32'hFFFF_FFF2, 1'b0, 5'd9, 32'hFFFF_FFF2, 1'b0};
    vecs[2] = '{1'b1, 32'd5, 32'd0, 5'd12, 0, 32'd0, 1'b1, 5'd30, 32'd5, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd31, 2, 32'hFFFE_0001, 1'b0, 5'd31, 32'hFFFE_0001, 1'b0};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'd2, 5'd4, 1, 32'd0, 1'b1, 5'd30, 32'd4, 1'b1};
    vecs[5] = '{1'b0, 32'd3, 32'd4, 5'd0, 0, 32'd12, 1'b0, 5'd0, 32'd12, 1'b0};

    // reset holds IDLE even with a request offered
    req_valid = 1'b1; md_rdy = 1'b1;
    repeat (2) @(negedge clock);
    #1 chk("rst_wb_valid", wb_valid, 0);
    chk("rst_pulses", {md_ctrl_div, md_ctrl_mult}, 0);
    chk("rst_wb_exc", wb_exc, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_opA", md_operandA, 0);
    chk("rst_opB", md_operandB, 0);
    @(negedge clock);
    #1 chk("rst_no_start", {md_ctrl_div, md_ctrl_mult}, 0);
    reset = 1'b0; req_valid = 1'b0; md_rdy = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // writeback backpressure: DONE holds 4 cycles, no accept in the exit cycle
    wb_ready = 1'b0;
    start_op(1'b0, 32'd9, 32'd9, 5'd5);
    @(negedge clock);
    md_rdy = 1'b1; md_result = 32'd81;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      md_rdy = 1'b0; md_result = 32'h1234_5678;
      #1 chk("hold_valid", wb_valid, 1);
      chk("hold_rd", wb_rd, 5);
      chk("hold_data", wb_data, 81);
      chk("hold_exc", wb_exc, 0);
    end
    @(negedge clock);
    wb_ready = 1'b1; req_valid = 1'b1; req_op = 1'b1; req_a = 32'd20; req_b = 32'd4; req_rd = 5'd6;
    #1 chk("exit_valid", wb_valid, 1);
    chk("exit_no_ready", req_ready, 0);
    @(negedge clock);
    #1 chk("exit_idle_ready", req_ready, 1);
    chk("exit_idle_no_wb", wb_valid, 0);
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("next_div_pulse", {md_ctrl_div, md_ctrl_mult}, 2);
    chk("next_opA", md_operandA, 20);
    @(negedge clock);
    flush = 1'b0;
    #1 chk("flush_start_idle", req_ready, 1);
    chk("flush_start_pulse", {md_ctrl_div, md_ctrl_mult}, 0);

    // flush in the third BUSY cycle, late md_rdy ignored
    start_op(1'b0, 32'd3, 32'd3, 5'd7);
    repeat (2) @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    #1 chk("flush_busy_ready", req_ready, 0);
    chk("flush_busy_no_wb", wb_valid, 0);
    @(negedge clock);
    flush = 1'b0;
    #1 chk("flush_busy_idle", stall, 0);
    repeat (9) @(negedge clock);
    md_rdy = 1'b1; md_result = 32'd9;
    #1 chk("late_rdy_no_wb", wb_valid, 0);
    @(negedge clock);
    md_rdy = 1'b0;
    #1 chk("late_rdy_still_idle", wb_valid, 0);
    chk("late_rdy_ready", req_ready, 1);

    // flush and md_rdy together in BUSY: flush wins
    start_op(1'b1, 32'd8, 32'd2, 5'd11);
    @(negedge clock);
    md_rdy = 1'b1; md_result = 32'd4; flush = 1'b1;
    #1 chk("flush_rdy_no_wb", wb_valid, 0);
    @(negedge clock);
    md_rdy = 1'b0; flush = 1'b0;
    #1 chk("flush_rdy_idle_no_wb", wb_valid, 0);
    chk("flush_rdy_idle_ready", req_ready, 1);

    // flush while DONE suppresses wb_valid
    wb_ready = 1'b0;
    start_op(1'b0, 32'd2, 32'd2, 5'd8);
    @(negedge clock);
    md_rdy = 1'b1; md_result = 32'd4;
    @(negedge clock);
    md_rdy = 1'b0;
    #1 chk("pre_flush_done_valid", wb_valid, 1);
    flush = 1'b1;
    #1 chk("flush_done_no_wb", wb_valid, 0);
    @(negedge clock);
    flush = 1'b0; wb_ready = 1'b1;
    #1 chk("flush_done_idle", wb_valid, 0);
    chk("flush_done_ready", req_ready, 1);

    // reset mid-BUSY clears everything
    start_op(1'b1, 32'd77, 32'd11, 5'd13);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1 chk("midrst_ready", req_ready, 1);
    chk("midrst_stall", stall, 0);
    chk("midrst_opA", md_operandA, 0);
    chk("midrst_opB", md_operandB, 0);
    chk("midrst_wb_data", wb_data, 0);
    chk("midrst_wb_rd", wb_rd, 0);
    chk("midrst_wb_exc", wb_exc, 0);
    chk("midrst_pulses", {md_ctrl_div, md_ctrl_mult}, 0);

`ifdef MULTDIV_TIMEOUT_EN
    // watchdog: 48 BUSY cycles without md_rdy end in a timeout record
    start_op(1'b0, 32'd1, 32'd1, 5'd2);
    n = 101;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      #1 if (wb_valid) begin
        n = c;
        break;
      end
    end
    chk("timeout_cycles", n, 49);
    chk("timeout_rd", wb_rd, 30);
    chk("timeout_data", wb_data, 6);
    chk("timeout_exc", wb_exc, 1);
    @(negedge clock);
    #1 chk("timeout_idle", req_ready, 1);
`else
    n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_W, default 5, register-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 48, watchdog limit; used only when MULTDIV_TIMEOUT_EN is defined.
REQ-004 SHALL have these ports, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  pipeline presents a mult/div instruction.
- req_op  in  1  operation select: 0 = mult, 1 = div.
- req_a, req_b  in  DATA_W  operands A and B.
- req_rd  in  REG_W  destination register.
- flush  in  1  squash any in-flight or offered operation.
- md_result  in  DATA_W  multdiv data_result.
- md_exception  in  1  multdiv data_exception.
- md_rdy  in  1  multdiv data_resultRDY.
- wb_ready  in  1  writeback accepts wb_valid.
- req_ready  out  1  request accepted this cycle.
- stall  out  1  freeze the upstream pipeline.
- md_operandA, md_operandB  out  DATA_W  multdiv operand inputs.
- md_ctrl_mult, md_ctrl_div  out  1  multdiv start pulses.
- wb_valid  out  1  writeback data valid.
- wb_rd  out  REG_W  writeback register.
- wb_data  out  DATA_W  writeback data.
- wb_exc  out  1  the result is an exception record.

Function
REQ-005 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-006 SHALL drive req_ready = (state==IDLE) && !flush; a request is accepted when req_valid && req_ready.
REQ-007 On accept, SHALL latch op, A, B and rd, then go to START.
REQ-008 In START, SHALL assert exactly one of md_ctrl_mult or md_ctrl_div for exactly one cycle, then go to BUSY.
REQ-009 SHALL hold md_operandA/B at the latched values from START until leaving DONE; in IDLE they SHALL hold their last values.
REQ-010 SHALL ignore md_rdy in START and sample it from the first BUSY cycle onward; this includes md_rdy asserted in that first cycle (divide-by-zero).
REQ-011 In BUSY with md_rdy=1, SHALL capture md_result and md_exception, then go to DONE.
REQ-012 Normal completion: wb_rd = latched rd, wb_data = captured result, wb_exc = 0.
REQ-013 Exception completion: wb_rd = 30, wb_data = 4 (mult) or 5 (div), wb_exc = 1.
REQ-014 In DONE, SHALL hold wb_valid=1 and stable wb_* until wb_ready=1, then go to IDLE.
REQ-015 SHALL accept no request in the DONE-exit cycle; at least one IDLE cycle separates operations.
REQ-016 SHALL drive stall = (state != IDLE) || (req_valid && state==IDLE).
REQ-017 Flush in START, BUSY or DONE SHALL force IDLE next cycle with no wb_valid; a start pulse already issued is not retracted and late md_rdy SHALL be ignored.
REQ-018 Flush and md_rdy in the same BUSY cycle: flush SHALL win.
REQ-019 wb_rd=0 with no exception SHALL still produce wb_valid; the register file discards it.

Reset
REQ-020 reset SHALL force IDLE and drive wb_valid=0, md_ctrl_mult=0, md_ctrl_div=0, wb_exc=0, and zero on wb_rd, wb_data, md_operandA and md_operandB.
REQ-021 reset SHALL take priority over every other input, including mid-operation, and SHALL clear the watchdog.

Configuration
REQ-022 With MULTDIV_TIMEOUT_EN defined, SHALL count BUSY cycles; reaching TIMEOUT_CYCLES without md_rdy SHALL go to DONE with wb_rd=30, wb_data=6, wb_exc=1.
REQ-023 Without MULTDIV_TIMEOUT_EN, BUSY SHALL wait indefinitely for md_rdy or flush, and no counter logic SHALL be present.

Structure
REQ-024 SHALL place in shared package multdiv_ctrl_pkg: the state enum, op encoding, RSTATUS_REG=30, and exception codes EXC_MULT=4, EXC_DIV=5, EXC_TIMEOUT=6.
REQ-025 SHALL implement the watchdog as sub-module md_watchdog (clear, enable, expired), instantiated only under MULTDIV_TIMEOUT_EN.

Verification
REQ-026 mult 7*6, rd=3, wb_ready=1 -> one start pulse, then wb_valid with rd=3, data=42, exc=0; stall high throughout.
REQ-027 div -100/7, rd=9 -> wb_data=0xFFFFFFF2 (-14), rd=9; operands stable from START to DONE exit.
REQ-028 div 5/0 with md_rdy in first BUSY cycle -> wb_rd=30, wb_data=5, wb_exc=1.
REQ-029 wb_ready held 0 for 4 cycles in DONE -> wb_* stable; IDLE one cycle after wb_ready=1; new req_valid accepted the following cycle.
REQ-030 flush in the 3rd BUSY cycle, md_rdy 10 cycles later -> no wb_valid; next request's start pulse one cycle after accept.
REQ-031 With MULTDIV_TIMEOUT_EN and md_rdy held 0 -> after 48 BUSY cycles, wb_rd=30, wb_data=6; reset mid-BUSY -> IDLE with all outputs zero.
